// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith/shift ops and iterative multiply/divide.
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             i_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             sn,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, hi, lo;
  logic [SHW-1:0]   cnt;
  logic             accept;
  assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign busy      = state == CALC;
  assign accept    = in_valid && in_ready;
  logic [WIDTH:0]   add_w, shl_w, shr_w, sar_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] s_res;
  logic             s_z, s_n, s_c, s_sn;
  always_comb begin
    sh    = b[SHW-1:0];
    add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, op == 4'd1 && i_carry};
    shl_w = {1'b0, a} << sh;
    shr_w = {a, 1'b0} >> sh;
    sar_w = $signed({a, 1'b0}) >>> sh;
    s_res = '0;
    s_c   = 1'b0;
    case (op)
      4'd0, 4'd1: {s_c, s_res} = add_w;
      4'd2: begin
        s_res = a - b;
        s_c   = a < b;
      end
      4'd3: s_res = a & b;
      4'd4: s_res = a | b;
      4'd5: s_res = a ^ b;
      4'd6: {s_c, s_res} = shl_w;
      4'd7: {s_res, s_c} = shr_w;
      4'd8: {s_res, s_c} = sar_w;
      default: s_res = '0;
    endcase
    s_z  = s_res == '0;
    s_n  = s_res[WIDTH-1];
    s_sn = s_n;
    if (op == 4'd9) begin
      s_z  = a == b;
      s_n  = a < b;
      s_sn = $signed(a) < $signed(b);
      s_c  = a < b;
    end
  end
  // hi/lo hold accumulator:multiplier for MULU and remainder:quotient for DIVU/REMU
  logic [WIDTH:0]   m_sum, d_t, d_sub;
  logic             d_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, f_res;
  logic             f_c;
  always_comb begin
    m_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
    d_t    = {hi, lo[WIDTH-1]};
    d_ge   = d_t >= {1'b0, b_r};
    d_sub  = d_t - {1'b0, b_r};
    nxt_hi = op_r == 4'd10 ? m_sum[WIDTH:1] : (d_ge ? d_sub[WIDTH-1:0] : d_t[WIDTH-1:0]);
    nxt_lo = op_r == 4'd10 ? {m_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], d_ge};
    f_res  = op_r == 4'd12 ? nxt_hi : nxt_lo;
    f_c    = op_r == 4'd10 ? |nxt_hi : b_r == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      sn     <= 1'b0;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
      cnt  <= '0;
      hi   <= '0;
      lo   <= op == 4'd10 ? b : a;
      if (op inside {4'd10, 4'd11, 4'd12}) begin
        state <= CALC;
      end else begin
        state  <= DONE;
        result <= s_res;
        z      <= s_z;
        n      <= s_n;
        c      <= s_c;
        sn     <= s_sn;
      end
    end else if (state == CALC) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + 1'b1;
      if (cnt == SHW'(WIDTH - 1)) begin
        state  <= DONE;
        result <= f_res;
        z      <= f_res == '0;
        n      <= f_res[WIDTH-1];
        sn     <= f_res[WIDTH-1];
        c      <= f_c;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, directed handshake/reset sequences and randomized scoreboard for alu_seq.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, i_carry, out_valid, out_ready;
  logic        z, n, c, sn, busy;
  logic [3:0]  op;
  logic [63:0] a, b, result;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .i_carry(i_carry), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .n(n), .c(c), .sn(sn), .busy(busy)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference: packs {result, z, n, c, sn}
  function automatic logic [67:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [127:0] p;
    logic [63:0]  r;
    logic         zz, nn, cc, ss;
    int           s;
    s  = int'(y[5:0]);
    r  = '0;
    cc = 1'b0;
    case (o)
      4'd0: begin p = {64'd0, x} + {64'd0, y}; r = p[63:0]; cc = p[64]; end
      4'd1: begin p = {64'd0, x} + {64'd0, y} + {127'd0, ci}; r = p[63:0]; cc = p[64]; end
      4'd2: begin r = x - y; cc = x < y; end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: begin r = x << s; cc = s == 0 ? 1'b0 : x[64-s]; end
      4'd7: begin r = x >> s; cc = s == 0 ? 1'b0 : x[s-1]; end
      4'd8: begin r = $signed(x) >>> s; cc = s == 0 ? 1'b0 : x[s-1]; end
      4'd10: begin p = {64'd0, x} * {64'd0, y}; r = p[63:0]; cc = p[127:64] != 0; end
      4'd11: begin r = y == 0 ? '1 : x / y; cc = y == 0; end
      4'd12: begin r = y == 0 ? x : x % y; cc = y == 0; end
      default: r = '0;
    endcase
    zz = r == 0;
    nn = r[63];
    ss = nn;
    if (o == 4'd9) begin
      zz = x == y;
      nn = x < y;
      ss = $signed(x) < $signed(y);
      cc = nn;
    end
    return {r, zz, nn, cc, ss};
  endfunction
  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  // scoreboard active only during the random phase
  logic [67:0] exp_q[$];
  bit          mon_en = 1'b0;
  always @(posedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_extra: got result %h with no op outstanding", result);
        end else chk("rand_out", {result, z, n, c, sn}, exp_q.pop_front());
      end
      if (!rst && in_valid && in_ready) exp_q.push_back(model(op, a, b, i_carry));
    end
  end
  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y, input logic ci,
                       output int lat, output int bz, output int bad);
    int k;
    @(negedge clk);
    op = o; a = x; b = y; i_carry = ci; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", o);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~x; b = ~y; op = 4'd3; i_carry = ~ci;
    lat = 0; bz = 0; bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bz++;
      if (busy && in_ready) bad++;
    end while (!out_valid && lat < 200);
  endtask
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        cin;
    logic [63:0] res;
    logic [3:0]  fl;
  } vec_t;
  vec_t vecs[23];
  initial begin
    int lat, bz, bad;
    bit iter;
    vecs[0]  = '{4'd0,  '1,                    64'd1,  1'b0, 64'd0,                 4'b1010};
    vecs[1]  = '{4'd9,  '1,                    64'd1,  1'b0, 64'd0,                 4'b0001};
    vecs[2]  = '{4'd2,  64'd1,                 64'd2,  1'b0, '1,                    4'b0111};
    vecs[3]  = '{4'd11, 64'd100,               64'd7,  1'b0, 64'd14,                4'b0000};
    vecs[4]  = '{4'd12, 64'd100,               64'd7,  1'b0, 64'd2,                 4'b0000};
    vecs[5]  = '{4'd11, 64'd100,               64'd0,  1'b0, '1,                    4'b0111};
    vecs[6]  = '{4'd12, 64'd100,               64'd0,  1'b0, 64'd100,               4'b0010};
    vecs[7]  = '{4'd10, 64'h1_0000_0000,       64'h1_0000_0000, 1'b0, 64'd0,        4'b1010};
    vecs[8]  = '{4'd6,  64'h8000_0000_0000_0001, 64'd1, 1'b0, 64'd2,                4'b0010};
    vecs[9]  = '{4'd7,  64'd5,                 64'd0,  1'b0, 64'd5,                 4'b0000};
    vecs[10] = '{4'd8,  64'h8000_0000_0000_0000, 64'd4, 1'b0, 64'hF800_0000_0000_0000, 4'b0101};
    vecs[11] = '{4'd1,  '1,                    64'd0,  1'b1, 64'd0,                 4'b1010};
    vecs[12] = '{4'd13, 64'd5,                 64'd3,  1'b0, 64'd0,                 4'b1000};
    vecs[13] = '{4'd5,  64'h1234,              64'h1234, 1'b0, 64'd0,               4'b1000};
    vecs[14] = '{4'd7,  64'd3,                 64'd1,  1'b0, 64'd1,                 4'b0010};
    vecs[15] = '{4'd9,  64'd5,                 64'd5,  1'b0, 64'd0,                 4'b1000};
    vecs[16] = '{4'd6,  64'd1,                 64'h41, 1'b0, 64'd2,                 4'b0000};
    vecs[17] = '{4'd4,  64'hF0,                64'h0F, 1'b0, 64'hFF,                4'b0000};
    vecs[18] = '{4'd3,  '1,                    64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 4'b0101};
    vecs[19] = '{4'd10, 64'd3,                 64'd5,  1'b0, 64'd15,                4'b0000};
    vecs[20] = '{4'd8,  64'h8000_0000_0000_0001, 64'd1, 1'b0, 64'hC000_0000_0000_0000, 4'b0111};
    vecs[21] = '{4'd0,  64'd1,                 64'd1,  1'b1, 64'd2,                 4'b0000};
    vecs[22] = '{4'd10, '1,                    64'd2,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0111};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0; i_carry = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {out_valid, busy, result, z, n, c, sn}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    foreach (vecs[i]) begin
      iter = vecs[i].op inside {4'd10, 4'd11, 4'd12};
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bz, bad);
      chk($sformatf("vec%0d_out", i), {result, z, n, c, sn}, {vecs[i].res, vecs[i].fl});
      chk($sformatf("vec%0d_lat", i), lat, iter ? 65 : 1);
      if (iter) begin
        chk($sformatf("vec%0d_busy", i), bz, 64);
        chk($sformatf("vec%0d_rdy_calc", i), bad, 0);
      end
    end
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(4'd6, 64'h8000_0000_0000_0001, 64'd1, 1'b0, lat, bz, bad);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, result, c}, {1'b1, 1'b0, 64'd2, 1'b1});
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 64'd2; b = 64'd3;
    #1;
    chk("bp_accept_same_cycle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_result", {out_valid, result, z, n, c, sn}, {1'b1, 64'd5, 4'b0000});
    @(negedge clk);
    op = 4'd11; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_calc_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_hi_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_calc_rst", {out_valid, busy, result, z, n, c, sn}, 0);
    rst = 1'b0;
    #1;
    chk("mid_calc_rst_ready", in_ready, 1);
    issue(4'd11, 64'd1000, 64'd10, 1'b0, lat, bz, bad);
    chk("after_rst_div", {result, z, n, c, sn}, {64'd100, 4'b0000});
    chk("after_rst_lat", lat, 65);
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      op        = 4'($urandom_range(0, 15));
      if (op inside {4'd10, 4'd11, 4'd12} && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 9));
      a         = rnd64();
      b         = rnd64();
      i_carry   = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    chk("rand_drain", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
